mtx_mem_responder: RTL and testbench
====================================

Name: mtx_mem_responder

Overview:
- Responder end of the matrix-memory read interface: accepts read requests from the solver core (rreq/addr) and returns 256-bit rows with a valid strobe after a fixed latency.
- Holds the matrix/vector storage. Matrix i occupies 17 rows: 16 A rows plus one b row.
- Inserts periodic refresh windows in which requests are refused, so the initiator's rrdy handling is exercised.
- Provides a preload write port for the testbench or system loader.

Parameters:
- DATA_W, 256, row width in bits.
- ADDR_W, 10, address width.
- DEPTH, 544, number of rows (32 matrices x 17).
- RD_LAT, 2, cycles from request acceptance to dout_vld (legal range 1-4).
- REF_PERIOD, 64, cycles between refresh window starts; 0 disables refresh.
- REF_LEN, 4, length of the refresh window in cycles (must be less than REF_PERIOD).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset.
- i_mem_rreq  in  1  read request from initiator.
- i_mem_addr  in  ADDR_W  read row address.
- o_mem_rrdy  out  1  responder can accept a request this cycle.
- o_mem_dout  out  DATA_W  read data.
- o_mem_dout_vld  out  1  o_mem_dout valid, one-cycle pulse per accepted request.
- i_ld_wen  in  1  preload write enable.
- i_ld_addr  in  ADDR_W  preload row address.
- i_ld_data  in  DATA_W  preload row data.
- o_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset: i_reset, asynchronous, active-high; clock i_clk.
  - All outputs reset to 0: rrdy, dout, dout_vld, err. FSM goes to INIT; refresh counter goes to 0; read pipeline valids cleared.
  - Storage array is not reset; contents survive reset.
- Handshake: a request is accepted on a rising edge where i_mem_rreq=1 and o_mem_rrdy=1.
  - Requests with rrdy=0 are ignored, not queued. The initiator holds rreq/addr until accepted.
- Latency: for a request accepted at edge T, o_mem_dout_vld=1 and o_mem_dout=row[addr] during the cycle after edge T+RD_LAT-1.
  - Example: with RD_LAT=2, data is visible 2 cycles after the accepting cycle.
  - dout_vld is high for exactly one cycle per request.
  - dout holds its last value when vld=0.
- Throughput: one request per cycle, no backpressure on the return path. The pipeline is an RD_LAT-deep shift of {valid, addr, range_ok}.
- FSM, with o_mem_rrdy registered from the next state:
  - INIT: rrdy=0 for 1 cycle, then go to SERVE.
  - SERVE: rrdy=1. Refresh counter increments every cycle. When REF_PERIOD!=0 and the counter reaches REF_PERIOD-1, go to REFRESH and clear the counter.
  - REFRESH: rrdy=0 for exactly REF_LEN cycles (length counter), then go to SERVE. The refresh counter keeps counting in REFRESH.
- In-flight reads accepted before a refresh window still complete on schedule during the window.
- Out of range (addr >= DEPTH): the request is still accepted and returns zeros with vld on schedule. o_err is set one cycle after acceptance and stays 1 until reset.
  - A preload with i_ld_addr >= DEPTH is dropped and also sets o_err.
- Preload: i_ld_wen writes on the rising edge and is allowed in any state, including REFRESH.
  - Same-cycle read acceptance and preload to the same address: the read returns the old data (read-first).
  - A preload before acceptance is always visible to a later read.
- Reset mid-operation: pending reads are discarded with no vld after reset, and the FSM restarts in INIT.
- Width rules: the refresh counter is clog2(REF_PERIOD+1) bits and the length counter is clog2(REF_LEN+1) bits. The address compare is unsigned.

Decomposition:
- Shared package `mtx_mem_pkg`: DATA_W, ADDR_W, ROWS_PER_MTX=17, MAX_MTX=32, and the FSM state encoding (INIT/SERVE/REFRESH), shared with the initiator side.
- One natural sub-module, `mtx_sram_1r1w`: DEPTH x DATA_W array, synchronous read-first read port plus write port, one-cycle read. The remaining RD_LAT-1 stages are pipeline registers in the parent.

Test Plan:
1. Preload row 0 = 256'hA5..A5 and row 16 = 256'h1; hold rreq with addr=16 from cycle 3 -> accepted at the first rrdy=1 edge; vld pulses once, 2 cycles later, with dout=256'h1.
2. Issue back-to-back reads of addr 0..16, one per cycle, with no refresh (REF_PERIOD=0) -> 17 consecutive vld cycles; data in address order; no gaps.
3. Use REF_PERIOD=8, REF_LEN=3 with rreq held continuously -> rrdy low for exactly 3 cycles every 8; the read accepted just before the window returns during the window; no request is lost or duplicated.
4. Read addr=600 with DEPTH=544 -> dout=0 with vld on schedule; o_err=1 from the next cycle and stays 1 across later good reads until i_reset.
5. Same edge: ld_wen to addr 5 with data=X, and a read of addr 5 accepted -> returns the old value; a read of 5 on the next cycle returns X.
6. Assert i_reset while 2 reads are in flight -> no vld after reset; rrdy=0 during INIT and 1 after; array contents are intact on re-read.

Source files
------------

// File: rtl/mtx_mem_pkg.sv
// Shared constants and FSM encoding for the matrix-memory read interface,
// used by both the responder and the solver-side initiator.
package mtx_mem_pkg;

    localparam int DATA_W       = 256;
    localparam int ADDR_W       = 10;
    localparam int ROWS_PER_MTX = 17;
    localparam int MAX_MTX      = 32;
    localparam int MEM_DEPTH    = ROWS_PER_MTX * MAX_MTX;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_SERVE   = 2'd1,
        ST_REFRESH = 2'd2
    } mtx_mem_state_e;

endpackage

// File: rtl/mtx_sram_1r1w.sv
// Row storage: one synchronous read-first read port and one write port.
// Contents are deliberately not reset so preloaded data survives i_reset.
module mtx_sram_1r1w #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 544
) (
    input  logic              i_clk,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    // Both ports sample the array before the write lands, giving read-first.
    always_ff @(posedge i_clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mtx_mem_responder.sv
// Responder end of the matrix-memory read interface: fixed-latency row reads,
// periodic refresh windows that drop rrdy, preload port and sticky range error.
//   state      | meaning
//   ST_INIT    | one cycle after reset, rrdy low
//   ST_SERVE   | accepting requests, refresh counter running
//   ST_REFRESH | REF_LEN cycles with rrdy low, in-flight reads still complete
module mtx_mem_responder #(
    parameter int DATA_W     = mtx_mem_pkg::DATA_W,
    parameter int ADDR_W     = mtx_mem_pkg::ADDR_W,
    parameter int DEPTH      = mtx_mem_pkg::MEM_DEPTH,
    parameter int RD_LAT     = 2,
    parameter int REF_PERIOD = 64,
    parameter int REF_LEN    = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mem_rreq,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic              o_mem_rrdy,
    output logic [DATA_W-1:0] o_mem_dout,
    output logic              o_mem_dout_vld,
    input  logic              i_ld_wen,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_err
);
    import mtx_mem_pkg::*;

    localparam int REF_W = (REF_PERIOD > 0) ? $clog2(REF_PERIOD + 1) : 1;
    localparam int LEN_W = (REF_LEN > 0) ? $clog2(REF_LEN + 1) : 1;
    localparam logic [REF_W-1:0]  REF_LAST = REF_W'((REF_PERIOD > 0) ? REF_PERIOD - 1 : 0);
    localparam logic [LEN_W-1:0]  LEN_LAST = LEN_W'((REF_LEN > 0) ? REF_LEN - 1 : 0);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    mtx_mem_state_e    r_state;
    logic [REF_W-1:0]  r_ref_cnt;
    logic [LEN_W-1:0]  r_len_cnt;
    logic              r_rrdy;
    logic              r_err;
    logic              r_v0;
    logic              r_ok0;

    logic              w_accept;
    logic              w_rd_ok;
    logic              w_ld_ok;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_d0;

    assign w_accept = i_mem_rreq && r_rrdy;
    assign w_rd_ok  = ({1'b0, i_mem_addr} < DEPTH_L);
    assign w_ld_ok  = ({1'b0, i_ld_addr} < DEPTH_L);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_INIT;
            r_ref_cnt <= '0;
            r_len_cnt <= '0;
            r_rrdy    <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_state <= ST_SERVE;
                    r_rrdy  <= 1'b1;
                end
                ST_SERVE: begin
                    if (REF_PERIOD != 0 && r_ref_cnt == REF_LAST) begin
                        r_state   <= ST_REFRESH;
                        r_rrdy    <= 1'b0;
                        r_ref_cnt <= '0;
                        r_len_cnt <= LEN_LAST;
                    end else begin
                        r_ref_cnt <= r_ref_cnt + 1'b1;
                    end
                end
                ST_REFRESH: begin
                    // Keep counting so window starts stay REF_PERIOD apart.
                    r_ref_cnt <= r_ref_cnt + 1'b1;
                    if (r_len_cnt == '0) begin
                        r_state <= ST_SERVE;
                        r_rrdy  <= 1'b1;
                    end else begin
                        r_len_cnt <= r_len_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_rrdy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err <= 1'b0;
            r_v0  <= 1'b0;
            r_ok0 <= 1'b0;
        end else begin
            r_v0 <= w_accept;
            if (w_accept) r_ok0 <= w_rd_ok;
            if ((w_accept && !w_rd_ok) || (i_ld_wen && !w_ld_ok)) r_err <= 1'b1;
        end
    end

    mtx_sram_1r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .i_clk   (i_clk),
        .i_re    (w_accept && w_rd_ok),
        .i_raddr (i_mem_addr),
        .o_rdata (w_rdata),
        .i_we    (i_ld_wen && w_ld_ok),
        .i_waddr (i_ld_addr),
        .i_wdata (i_ld_data)
    );

    // Out-of-range reads skip the array and are forced to zero here.
    assign w_d0 = r_ok0 ? w_rdata : '0;

    generate
        if (RD_LAT <= 1) begin : g_lat1
            assign o_mem_dout     = w_d0;
            assign o_mem_dout_vld = r_v0;
        end else begin : g_latn
            logic [DATA_W-1:0] r_dat [1:RD_LAT-1];
            logic              r_vs  [1:RD_LAT-1];

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    for (int k = 1; k < RD_LAT; k++) begin
                        r_dat[k] <= '0;
                        r_vs[k]  <= 1'b0;
                    end
                end else begin
                    r_vs[1] <= r_v0;
                    if (r_v0) r_dat[1] <= w_d0;
                    for (int k = 2; k < RD_LAT; k++) begin
                        r_vs[k] <= r_vs[k-1];
                        if (r_vs[k-1]) r_dat[k] <= r_dat[k-1];
                    end
                end
            end

            assign o_mem_dout     = r_dat[RD_LAT-1];
            assign o_mem_dout_vld = r_vs[RD_LAT-1];
        end
    endgenerate

    assign o_mem_rrdy = r_rrdy;
    assign o_err      = r_err;

endmodule

// File: tb/tb_mtx_mem_responder.sv
// Directed bench: instance A has refresh disabled, instance B uses an 8-cycle
// refresh period with a 3-cycle window.
module tb_mtx_mem_responder;

    localparam int DW = 256;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_a, rst_b;
    logic          a_rreq, a_rrdy, a_vld, a_ld_wen, a_err;
    logic [AW-1:0] a_addr, a_ld_addr;
    logic [DW-1:0] a_dout, a_ld_data;
    logic          b_rreq, b_rrdy, b_vld, b_ld_wen, b_err;
    logic [AW-1:0] b_addr, b_ld_addr;
    logic [DW-1:0] b_dout, b_ld_data;

    logic [DW-1:0] mdl_a [0:16];
    logic [DW-1:0] mdl_b [0:7];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mtx_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(544), .RD_LAT(2),
                        .REF_PERIOD(0), .REF_LEN(4)) u_dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_mem_rreq(a_rreq), .i_mem_addr(a_addr),
        .o_mem_rrdy(a_rrdy), .o_mem_dout(a_dout), .o_mem_dout_vld(a_vld),
        .i_ld_wen(a_ld_wen), .i_ld_addr(a_ld_addr), .i_ld_data(a_ld_data), .o_err(a_err));

    mtx_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(544), .RD_LAT(2),
                        .REF_PERIOD(8), .REF_LEN(3)) u_dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_mem_rreq(b_rreq), .i_mem_addr(b_addr),
        .o_mem_rrdy(b_rrdy), .o_mem_dout(b_dout), .o_mem_dout_vld(b_vld),
        .i_ld_wen(b_ld_wen), .i_ld_addr(b_ld_addr), .i_ld_data(b_ld_data), .o_err(b_err));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int k, input logic [31:0] base);
        logic [31:0] w;
        w = base + 32'(k);
        return {8{w}};
    endfunction

    // Expected rrdy of instance B after the n-th edge following reset release.
    function automatic logic exp_rdy_b(input int n);
        if (n <= 0) return 1'b0;
        if (n < 9) return 1'b1;
        return (((n - 9) % 8) < 3) ? 1'b0 : 1'b1;
    endfunction

    task automatic ld_a(input int addr, input logic [DW-1:0] data);
        a_ld_wen = 1'b1; a_ld_addr = AW'(addr); a_ld_data = data;
        tick;
        a_ld_wen = 1'b0;
        if (addr < 17) mdl_a[addr] = data;
    endtask

    task automatic ld_b(input int addr, input logic [DW-1:0] data);
        b_ld_wen = 1'b1; b_ld_addr = AW'(addr); b_ld_data = data;
        tick;
        b_ld_wen = 1'b0;
        mdl_b[addr] = data;
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1;
        tick; tick;
        checks++; if (a_rrdy !== 1'b0) begin errors++; $display("FAIL reset_rrdy got %b want 0", a_rrdy); end
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", a_vld); end
        checks++; if (a_dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", a_dout); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", a_err); end
        rst_a = 1'b0; rst_b = 1'b0;
        checks++; if (a_rrdy !== 1'b0) begin errors++; $display("FAIL init_rrdy got %b want 0", a_rrdy); end
        tick;
        checks++; if (a_rrdy !== 1'b1) begin errors++; $display("FAIL serve_rrdy got %b want 1", a_rrdy); end
        ld_a(0, {32{8'hA5}});
        ld_a(16, 256'h1);
        for (int k = 1; k < 16; k++) ld_a(k, pat(k, 32'hC0DE0000));
        for (int k = 0; k < 8; k++) ld_b(k, pat(k, 32'hBEEF0000));
    endtask

    task automatic test_single_read;
        int wait_cnt;
        a_rreq = 1'b1; a_addr = 10'd16;
        wait_cnt = 0;
        while (a_rrdy !== 1'b1 && wait_cnt < 8) begin tick; wait_cnt++; end
        checks++; if (a_rrdy !== 1'b1) begin errors++; $display("FAIL single_rrdy_timeout got %b want 1", a_rrdy); end
        tick;
        a_rreq = 1'b0;
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL single_early_vld got %b want 0", a_vld); end
        tick;
        checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL single_vld got %b want 1", a_vld); end
        checks++; if (a_dout !== 256'h1) begin errors++; $display("FAIL single_dout got %h want 1", a_dout); end
        tick;
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL single_vld_pulse got %b want 0", a_vld); end
        checks++; if (a_dout !== 256'h1) begin errors++; $display("FAIL single_dout_hold got %h want 1", a_dout); end
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c <= 18; c++) begin
            a_rreq = (c < 17);
            a_addr = AW'(c < 17 ? c : 0);
            tick;
            checks++;
            if (a_vld !== (c >= 1 && c <= 17)) begin
                errors++; $display("FAIL b2b_vld cycle %0d got %b want %b", c, a_vld, (c >= 1 && c <= 17));
            end
            if (c >= 1 && c <= 17) begin
                checks++;
                if (a_dout !== mdl_a[c-1]) begin
                    errors++; $display("FAIL b2b_dout row %0d got %h want %h", c - 1, a_dout, mdl_a[c-1]);
                end
            end
        end
        a_rreq = 1'b0;
    endtask

    task automatic test_refresh;
        int k, vld_seen, cur_addr, pend_addr;
        logic pend, acc;
        b_rreq = 1'b0;
        rst_b = 1'b1;
        tick;
        rst_b = 1'b0;
        checks++; if (b_rrdy !== 1'b0) begin errors++; $display("FAIL ref_init_rrdy got %b want 0", b_rrdy); end
        k = 0; vld_seen = 0; cur_addr = 0; pend = 1'b0; pend_addr = 0;
        b_rreq = 1'b1; b_addr = '0;
        for (int n = 1; n <= 41; n++) begin
            acc = exp_rdy_b(n - 1) && (n <= 40);
            if (n == 41) b_rreq = 1'b0;
            tick;
            checks++;
            if (b_rrdy !== exp_rdy_b(n)) begin
                errors++; $display("FAIL ref_rrdy edge %0d got %b want %b", n, b_rrdy, exp_rdy_b(n));
            end
            checks++;
            if (b_vld !== pend) begin
                errors++; $display("FAIL ref_vld edge %0d got %b want %b", n, b_vld, pend);
            end
            if (b_vld === 1'b1) vld_seen++;
            if (pend) begin
                checks++;
                if (b_dout !== mdl_b[pend_addr]) begin
                    errors++; $display("FAIL ref_dout edge %0d got %h want %h", n, b_dout, mdl_b[pend_addr]);
                end
            end
            pend = acc; pend_addr = cur_addr;
            if (acc) begin
                k++; cur_addr = k % 8; b_addr = AW'(cur_addr);
            end
        end
        tick;
        if (b_vld === 1'b1) vld_seen++;
        checks++;
        if (vld_seen != k) begin errors++; $display("FAIL ref_count got %0d want %0d", vld_seen, k); end
    endtask

    task automatic test_out_of_range;
        a_rreq = 1'b1; a_addr = 10'd600;
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL oor_err_pre got %b want 0", a_err); end
        tick;
        a_rreq = 1'b0;
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL oor_err_set got %b want 1", a_err); end
        tick;
        checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL oor_vld got %b want 1", a_vld); end
        checks++; if (a_dout !== '0) begin errors++; $display("FAIL oor_dout got %h want 0", a_dout); end
        a_rreq = 1'b1; a_addr = 10'd16;
        tick;
        a_rreq = 1'b0;
        tick;
        checks++; if (a_dout !== 256'h1) begin errors++; $display("FAIL oor_good_dout got %h want 1", a_dout); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL oor_err_sticky got %b want 1", a_err); end
    endtask

    task automatic test_read_first;
        logic [DW-1:0] old_v, new_v;
        old_v = mdl_a[5];
        new_v = {8{32'hDEAD5A5A}};
        a_ld_wen = 1'b1; a_ld_addr = 10'd5; a_ld_data = new_v;
        a_rreq = 1'b1; a_addr = 10'd5;
        tick;
        a_ld_wen = 1'b0;
        mdl_a[5] = new_v;
        tick;
        a_rreq = 1'b0;
        checks++; if (a_dout !== old_v) begin errors++; $display("FAIL rf_old got %h want %h", a_dout, old_v); end
        tick;
        checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL rf_new_vld got %b want 1", a_vld); end
        checks++; if (a_dout !== new_v) begin errors++; $display("FAIL rf_new got %h want %h", a_dout, new_v); end
    endtask

    task automatic test_reset_midflight;
        a_rreq = 1'b1; a_addr = 10'd1;
        tick;
        a_addr = 10'd2;
        tick;
        a_rreq = 1'b0;
        rst_a = 1'b1;
        #1;
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld got %b want 0", a_vld); end
        checks++; if (a_rrdy !== 1'b0) begin errors++; $display("FAIL mid_rst_rrdy got %b want 0", a_rrdy); end
        tick; tick;
        rst_a = 1'b0;
        checks++; if (a_rrdy !== 1'b0) begin errors++; $display("FAIL mid_init_rrdy got %b want 0", a_rrdy); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL mid_err_clr got %b want 0", a_err); end
        tick;
        checks++; if (a_rrdy !== 1'b1) begin errors++; $display("FAIL mid_serve_rrdy got %b want 1", a_rrdy); end
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL mid_stale_vld got %b want 0", a_vld); end
        a_rreq = 1'b1; a_addr = 10'd16;
        tick;
        a_addr = 10'd5;
        tick;
        a_rreq = 1'b0;
        checks++; if (a_dout !== mdl_a[16]) begin errors++; $display("FAIL mid_keep16 got %h want %h", a_dout, mdl_a[16]); end
        tick;
        checks++; if (a_dout !== mdl_a[5]) begin errors++; $display("FAIL mid_keep5 got %h want %h", a_dout, mdl_a[5]); end
        ld_a(700, {8{32'h0BAD0BAD}});
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL ld_oor_err got %b want 1", a_err); end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_rreq = 1'b0; a_addr = '0; a_ld_wen = 1'b0; a_ld_addr = '0; a_ld_data = '0;
        b_rreq = 1'b0; b_addr = '0; b_ld_wen = 1'b0; b_ld_addr = '0; b_ld_data = '0;
        test_reset;
        test_single_read;
        test_back_to_back;
        test_refresh;
        test_out_of_range;
        test_read_first;
        test_reset_midflight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
